// File: rtl/uart_rx_cfg.sv
// Runtime-configurable oversampling UART receiver.
// Supports 5..DBIT_MAX data bits, none/even/odd parity and 1 or 2 stop bits.
// Each bit is resolved by a 3-sample majority vote.
// Parity, framing and break status are reported per frame.
module uart_rx_cfg #(
    parameter int unsigned DBIT_MAX    = 9,
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx,
    input  logic                s_tick,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic                rx_done_tick,
    output logic [DBIT_MAX-1:0] dout,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    output logic                busy
);

    localparam int unsigned SW = $clog2(OVS);
    localparam logic [SW-1:0] SampleA  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SampleB  = SW'(OVS / 2);
    localparam logic [SW-1:0] DecideAt = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] LastAt   = SW'(OVS - 1);
    localparam logic [3:0]    DbitMax4 = 4'(DBIT_MAX);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2, StBrkWait
    } state_e;

    state_e                r_state, w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SW-1:0]         r_s;
    logic [3:0]            r_n;
    logic                  r_smp_a, r_smp_b;
    logic [DBIT_MAX-1:0]   r_shift;
    logic [3:0]            r_dbits;
    logic                  r_par_en, r_par_odd, r_stop2;
    logic                  r_par_acc, r_perr, r_ferr, r_zero, r_brk;
    logic                  r_done;
    logic [DBIT_MAX-1:0]   r_dout;
    logic                  r_perr_o, r_ferr_o, r_brk_o;

    logic                  w_rxs, w_dec, w_end, w_vote, w_done;
    logic                  w_ferr_fin, w_brk_fin;
    logic [3:0]            w_dbits_clamp;

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_dec      = s_tick && (r_s == DecideAt);
    assign w_end      = s_tick && (r_s == LastAt);
    assign w_vote     = (r_smp_a & r_smp_b) | (r_smp_a & w_rxs) | (r_smp_b & w_rxs);
    assign w_ferr_fin = r_ferr | ~w_vote;
    // Break is judged on the first stop bit; a second stop bit reuses the stored verdict.
    assign w_brk_fin  = (r_state == StStop1) ? (r_zero & ~w_vote) : r_brk;

    // Clamp the requested data bit count into 5..DBIT_MAX.
    always_comb begin
        w_dbits_clamp = cfg_dbits;
        if (cfg_dbits < 4'd5)          w_dbits_clamp = 4'd5;
        else if (cfg_dbits > DbitMax4) w_dbits_clamp = DbitMax4;
    end

    // Input synchroniser, idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '1;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    // Next state; the final stop bit completes the frame at its decision tick.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            StIdle:    if (!w_rxs) w_state_next = StStart;
            StStart: begin
                if (w_dec && w_vote) w_state_next = StIdle;
                else if (w_end)      w_state_next = StData;
            end
            StData: begin
                if (w_end && (r_n == r_dbits - 4'd1))
                    w_state_next = r_par_en ? StParity : StStop1;
            end
            StParity:  if (w_end) w_state_next = StStop1;
            StStop1: begin
                if (w_dec && !r_stop2) begin
                    w_done       = 1'b1;
                    w_state_next = w_ferr_fin ? StBrkWait : StIdle;
                end else if (w_end && r_stop2) begin
                    w_state_next = StStop2;
                end
            end
            StStop2: begin
                if (w_dec) begin
                    w_done       = 1'b1;
                    w_state_next = w_ferr_fin ? StBrkWait : StIdle;
                end
            end
            StBrkWait: if (w_rxs) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Bit timing, sampling, data assembly and per-frame status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s       <= '0;
            r_n       <= '0;
            r_smp_a   <= 1'b0;
            r_smp_b   <= 1'b0;
            r_shift   <= '0;
            r_dbits   <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_par_acc <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_zero    <= 1'b0;
            r_brk     <= 1'b0;
            r_done    <= 1'b0;
            r_dout    <= '0;
            r_perr_o  <= 1'b0;
            r_ferr_o  <= 1'b0;
            r_brk_o   <= 1'b0;
        end else begin
            r_done <= w_done;
            // Restart the bit period on every state change and at each bit boundary.
            if (r_state == StIdle || r_state == StBrkWait || w_state_next != r_state || w_end)
                r_s <= '0;
            else if (s_tick)
                r_s <= r_s + 1'b1;
            if (s_tick && r_s == SampleA) r_smp_a <= w_rxs;
            if (s_tick && r_s == SampleB) r_smp_b <= w_rxs;
            case (r_state)
                StIdle: begin
                    if (!w_rxs) begin
                        r_dbits   <= w_dbits_clamp;
                        r_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                        r_par_odd <= (cfg_parity == 2'b10);
                        r_stop2   <= cfg_stop2;
                        r_shift   <= '0;
                        r_n       <= '0;
                        r_par_acc <= 1'b0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_brk     <= 1'b0;
                        r_zero    <= 1'b1;
                    end
                end
                StData: begin
                    if (w_dec) begin
                        for (int i = 0; i < int'(DBIT_MAX); i++)
                            if (r_n == 4'(i)) r_shift[i] <= w_vote;
                        r_par_acc <= r_par_acc ^ w_vote;
                        r_zero    <= r_zero & ~w_vote;
                    end
                    if (w_end && (r_n != r_dbits - 4'd1)) r_n <= r_n + 4'd1;
                end
                StParity: begin
                    if (w_dec) begin
                        r_perr <= r_par_acc ^ w_vote ^ r_par_odd;
                        r_zero <= r_zero & ~w_vote;
                    end
                end
                StStop1: begin
                    if (w_dec) begin
                        r_ferr <= w_ferr_fin;
                        r_brk  <= w_brk_fin;
                    end
                end
                StStop2:  if (w_dec) r_ferr <= w_ferr_fin;
                default: ;
            endcase
            if (w_done) begin
                r_dout   <= r_shift;
                r_perr_o <= r_perr;
                r_ferr_o <= w_ferr_fin;
                r_brk_o  <= w_brk_fin;
            end
        end
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign parity_err   = r_perr_o;
    assign frame_err    = r_ferr_o;
    assign break_det    = r_brk_o;
    assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int TDIV = 4;
    localparam int OVS  = 16;
    localparam int BIT  = TDIV * OVS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic [3:0] cfg_dbits = 4'd8;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       rx_done_tick;
    logic [8:0] dout;
    logic       parity_err, frame_err, break_det, busy;

    int checks = 0;
    int errors = 0;
    int tcnt = 0;
    logic [12:0] mon_q[$];
    logic [12:0] last_exp;

    uart_rx_cfg #(.DBIT_MAX(9), .OVS(OVS), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .s_tick(s_tick),
        .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .rx_done_tick(rx_done_tick), .dout(dout), .parity_err(parity_err),
        .frame_err(frame_err), .break_det(break_det), .busy(busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk wide every TDIV clocks.
    always @(negedge clk) begin
        tcnt = (tcnt + 1) % TDIV;
        s_tick = (tcnt == 0);
    end

    // Record every completed frame as {busy, break, frame_err, parity_err, dout}.
    always @(negedge clk) begin
        if (rx_done_tick) mon_q.push_back({busy, break_det, frame_err, parity_err, dout});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input logic [3:0] c);
        if (c < 5) return 5;
        if (c > 9) return 9;
        return int'(c);
    endfunction

    // Frame-level reference: what the receiver should report for a given frame.
    function automatic logic [12:0] model(input logic [3:0] cd, input logic [1:0] par,
                                          input logic s2en, input logic [8:0] data,
                                          input logic pbit, input logic st1, input logic st2);
        int   nb   = clamp(cd);
        logic [8:0] d = data & 9'((1 << nb) - 1);
        int   ones = $countones(d);
        bit   pen  = (par == 2'b01) || (par == 2'b10);
        bit   odd  = (par == 2'b10);
        bit   perr = pen && (((ones + int'(pbit)) % 2) != int'(odd));
        bit   ferr = !st1 || (s2en && !st2);
        bit   brk  = (d == 0) && (!pen || !pbit) && !st1;
        // After a framing error the receiver waits for the line to go high, so it stays busy.
        return {ferr, brk, ferr, perr, d};
    endfunction

    task automatic drive(input logic b, input int clks);
        rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] data, input int nb, input bit has_par,
                              input logic pbit, input logic st1, input bit has_s2,
                              input logic st2, input int spike_bit);
        drive(1'b0, BIT);
        for (int i = 0; i < nb; i++) begin
            if (i == spike_bit) begin
                drive(data[i], BIT / 2 - 2);
                drive(~data[i], TDIV);
                drive(data[i], BIT - (BIT / 2 - 2) - TDIV);
            end else begin
                drive(data[i], BIT);
            end
        end
        if (has_par) drive(pbit, BIT);
        drive(st1, BIT);
        if (has_s2) drive(st2, BIT);
        rx = 1'b1;
    endtask

    task automatic check_next(input string tag, input logic [12:0] exp);
        logic [12:0] got;
        if (mon_q.size() == 0) got = 'x;
        else                   got = mon_q.pop_front();
        check({tag, "_dout"}, 32'(got[8:0]), 32'(exp[8:0]));
        check({tag, "_perr"}, 32'(got[9]), 32'(exp[9]));
        check({tag, "_ferr"}, 32'(got[10]), 32'(exp[10]));
        check({tag, "_brk"}, 32'(got[11]), 32'(exp[11]));
        check({tag, "_busy"}, 32'(got[12]), 32'(exp[12]));
    endtask

    task automatic run_frame(input string tag, input logic [3:0] cd, input logic [1:0] par,
                             input logic s2en, input logic [8:0] data, input logic pbit,
                             input logic st1, input logic st2, input int spike_bit);
        logic [12:0] exp;
        cfg_dbits  = cd;
        cfg_parity = par;
        cfg_stop2  = s2en;
        send_frame(data, clamp(cd), (par == 2'b01) || (par == 2'b10), pbit, st1, s2en, st2,
                   spike_bit);
        drive(1'b1, 2 * BIT);
        exp = model(cd, par, s2en, data, pbit, st1, st2);
        check({tag, "_count"}, 32'(mon_q.size()), 32'd1);
        check_next(tag, exp);
        last_exp = exp;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_flags", {29'd0, parity_err, frame_err, break_det}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(rx_done_tick), 32'd0);
        reset_n = 1'b1;
        drive(1'b1, 2 * BIT);

        // 8N1, 0xA5.
        run_frame("8n1_a5", 4'd8, 2'b00, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1);
        // 7E2 with wrong then correct parity bit.
        run_frame("7e2_bad", 4'd7, 2'b01, 1'b1, 9'h041, 1'b1, 1'b1, 1'b1, -1);
        run_frame("7e2_ok", 4'd7, 2'b01, 1'b1, 9'h041, 1'b0, 1'b1, 1'b1, -1);
        // 9O1, all ones, parity bit 0.
        run_frame("9o1", 4'd9, 2'b10, 1'b0, 9'h1FF, 1'b0, 1'b1, 1'b1, -1);
        // Data bit count below 5 acts as 5.
        run_frame("dbits3", 4'd3, 2'b00, 1'b0, 9'h1F5, 1'b0, 1'b1, 1'b1, -1);

        // Short low glitch: start aborts, nothing reported, outputs held.
        cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        drive(1'b0, 8);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        drive(1'b0, 4 * TDIV - 8);
        drive(1'b1, 2 * BIT);
        check("glitch_count", 32'(mon_q.size()), 32'd0);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_dout", 32'(dout), 32'(last_exp[8:0]));

        // One-tick spike inside a data bit is voted out.
        run_frame("spike", 4'd8, 2'b00, 1'b0, 9'h096, 1'b0, 1'b1, 1'b1, 3);

        // Line break: held low for three frame times gives exactly one report.
        cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        drive(1'b0, 30 * BIT);
        check("brk_count", 32'(mon_q.size()), 32'd1);
        check("brk_busy_wait", 32'(busy), 32'd1);
        check_next("brk", model(4'd8, 2'b00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 2 * BIT);
        check("brk_busy_after", 32'(busy), 32'd0);
        check("brk_no_extra", 32'(mon_q.size()), 32'd0);
        run_frame("after_brk", 4'd8, 2'b00, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, -1);

        // Reset in the middle of the data bits.
        drive(1'b0, 3 * BIT);
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_flags", {29'd0, parity_err, frame_err, break_det}, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rx = 1'b1;
        drive(1'b1, 4);
        reset_n = 1'b1;
        drive(1'b1, 2 * BIT);
        check("mid_rst_count", 32'(mon_q.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        send_frame(9'h0AA, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        drive(1'b1, 2 * BIT);
        check("b2b_count", 32'(mon_q.size()), 32'd2);
        check_next("b2b_1", model(4'd8, 2'b00, 1'b0, 9'h055, 1'b0, 1'b1, 1'b1));
        check_next("b2b_2", model(4'd8, 2'b00, 1'b0, 9'h0AA, 1'b0, 1'b1, 1'b1));

        // Randomized frames across all configurations, including bad parity and stop bits.
        for (int k = 0; k < 16; k++) begin
            run_frame($sformatf("rnd%0d", k), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
